// File: rtl/mem_resp_pkg.sv
// ============================================================================
// Module  : mem_resp_pkg
// Brief   : Shared types and constants for the native memory responder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_resp_pkg;

  localparam int RD_LAT_MAX = 4;

  // Width needed to hold values 0 .. max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

  localparam int RD_CNT_W = cnt_width(RD_LAT_MAX);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ACCESS = 4'b0010,
    S_WAIT   = 4'b0100,
    S_ACK    = 4'b1000
  } mem_resp_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_resp_rd_pipe.sv
// ============================================================================
// Module  : mem_resp_rd_pipe
// Brief   : SRAM read-latency down-counter and read-data capture register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_resp_rd_pipe
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [RD_CNT_W-1:0] C_CNT_LOAD = RD_CNT_W'(RD_LATENCY - 1);

  logic                  busy_q, busy_d;
  logic [RD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign done_o = busy_q && (cnt_q == '0);
  assign data_o = data_q;

  // The data register holds a value for exactly one cycle after capture,
  // which lines up with the ack cycle of the owning FSM.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    data_d = '0;
    if (clr_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = C_CNT_LOAD;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        data_d = rdata_i;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_native_responder.sv
// ============================================================================
// Module  : mem_native_responder
// Brief   : Native memory interface target driving a single-port sync SRAM.
//           Optional address range checking: MEM_RESP_ADDR_CHK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_native_responder
  import mem_resp_pkg::*;
#(
  parameter int MEM_DATA_WIDTH  = 64,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int SRAM_DEPTH      = 1024,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       soft_rst,
  input  logic                       mem_req_vld,
  output logic                       mem_ack_vld,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  input  logic                       mem_wr_en,
  input  logic                       mem_rd_en,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_wr_data,
  output logic [MEM_DATA_WIDTH-1:0]  mem_rd_data,
  output logic                       mem_err,
  output logic                       sram_ce,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DATA_WIDTH-1:0]  sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]  sram_rdata
);

  mem_resp_state_e state_q, state_d;

  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic                       ce_q, ce_d;
  logic                       we_q, we_d;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [MEM_DATA_WIDTH-1:0]  sram_wdata_q, sram_wdata_d;

  logic                       w_cmd_ok;
  logic                       w_addr_ok;
  logic                       w_rd_start;
  logic                       w_rd_done;
  logic [MEM_DATA_WIDTH-1:0]  w_rd_data;

  assign w_cmd_ok = mem_wr_en ^ mem_rd_en;

`ifdef MEM_RESP_ADDR_CHK_EN
  localparam logic [MEM_ADDR_WIDTH-1:0] C_DEPTH = MEM_ADDR_WIDTH'(SRAM_DEPTH);
  assign w_addr_ok = (mem_addr < C_DEPTH);
`else
  assign w_addr_ok = 1'b1;
  // Upper address bits are deliberately dropped so accesses alias.
  generate
    if (MEM_ADDR_WIDTH > SRAM_ADDR_WIDTH) begin : g_addr_alias
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^mem_addr[MEM_ADDR_WIDTH-1:SRAM_ADDR_WIDTH];
    end
  endgenerate
`endif

  assign w_rd_start = (state_q == S_ACCESS) && !we_q && !soft_rst;

  mem_resp_rd_pipe #(
    .DATA_WIDTH (MEM_DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (soft_rst),
    .start_i (w_rd_start),
    .rdata_i (sram_rdata),
    .done_o  (w_rd_done),
    .data_o  (w_rd_data)
  );

  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    ce_d         = 1'b0;
    we_d         = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    if (soft_rst) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (mem_req_vld) begin
            if (w_cmd_ok && w_addr_ok) begin
              state_d      = S_ACCESS;
              ce_d         = 1'b1;
              we_d         = mem_wr_en;
              sram_addr_d  = mem_addr[SRAM_ADDR_WIDTH-1:0];
              sram_wdata_d = mem_wr_data;
            end else begin
              state_d = S_ACK;
              ack_d   = 1'b1;
`ifdef MEM_RESP_ADDR_CHK_EN
              err_d   = 1'b1;
`endif
            end
          end
        end
        S_ACCESS: begin
          if (we_q) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_rd_done) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
          end
        end
        S_ACK:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      ce_q         <= ce_d;
      we_q         <= we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign mem_ack_vld = ack_q;
  assign mem_err     = err_q;
  assign mem_rd_data = w_rd_data;
  assign sram_ce     = ce_q;
  assign sram_we     = we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wdata  = sram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_native_responder.sv
// ============================================================================
// Module  : tb_mem_native_responder
// Brief   : Self-checking bench; two responders (RD_LATENCY 1 and 4) with SRAM models.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_native_responder;

`ifdef MEM_RESP_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          ce;
    int          start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] mem_addr = '0;
  logic        mem_wr_en = 1'b0;
  logic        mem_rd_en = 1'b0;
  logic [63:0] mem_wr_data = '0;

  logic        ack1, err1, ce1, we1, ack4, err4, ce4, we4;
  logic [63:0] rdat1, rdat4, wdat1, wdat4, srd1, srd4;
  logic [9:0]  addr1, addr4;
  wire  [1:0]  ack_w = {ack4, ack1};

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   ce_cnt [2];
  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl [13];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_native_responder #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .mem_req_vld(req[0]), .mem_ack_vld(ack1),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(rdat1), .mem_err(err1),
    .sram_ce(ce1), .sram_we(we1), .sram_addr(addr1), .sram_wdata(wdat1), .sram_rdata(srd1)
  );

  mem_native_responder #(.RD_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .mem_req_vld(req[1]), .mem_ack_vld(ack4),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(rdat4), .mem_err(err4),
    .sram_ce(ce4), .sram_we(we4), .sram_addr(addr4), .sram_wdata(wdat4), .sram_rdata(srd4)
  );

  // SRAM models: read data is only valid exactly RD_LATENCY cycles after ce.
  logic [63:0] mem1 [1024];
  logic [63:0] mem4 [1024];
  logic [63:0] rp1 [4];
  logic [63:0] rp4 [4];
  logic        rv1 [4];
  logic        rv4 [4];

  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem1[k] = '0;
      mem4[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      rv1[k] = 1'b0; rv4[k] = 1'b0; rp1[k] = '0; rp4[k] = '0;
    end
  end

  always @(posedge clk) begin
    if (ce1 && we1) mem1[addr1] <= wdat1;
    if (ce4 && we4) mem4[addr4] <= wdat4;
    rv1[0] <= ce1 && !we1;
    rp1[0] <= mem1[addr1];
    rv4[0] <= ce4 && !we4;
    rp4[0] <= mem4[addr4];
    for (int k = 1; k < 4; k++) begin
      rv1[k] <= rv1[k-1]; rp1[k] <= rp1[k-1];
      rv4[k] <= rv4[k-1]; rp4[k] <= rp4[k-1];
    end
  end

  assign srd1 = rv1[0] ? rp1[0] : 64'hBADB_ADBA_DBAD_BAD1;
  assign srd4 = rv4[3] ? rp4[3] : 64'hBADB_ADBA_DBAD_BAD4;

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, i, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic ack, input logic [63:0] d, input logic e,
                     input logic ce, input logic we, input logic [9:0] a, input logic [63:0] wd);
    exp_t x;
    if (ce) begin
      ce_cnt[i]++;
    end else begin
      chk("sram_addr_idle", i, {54'd0, a}, 64'd0);
      chk("sram_wdata_idle", i, wd, 64'd0);
      chk("sram_we_idle", i, {63'd0, we}, 64'd0);
    end
    if (!ack) begin
      chk("rd_data_idle", i, d, 64'd0);
      chk("err_idle", i, {63'd0, e}, 64'd0);
    end else if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL unexpected_ack dut%0d: got ack at cycle %0d, expected none", i, cyc);
    end else begin
      if (i == 0) x = q0.pop_front();
      else        x = q1.pop_front();
      chk("ack_data", i, d, x.data);
      chk("ack_err", i, {63'd0, e}, {63'd0, x.err});
      chk("ack_latency", i, 64'(cyc - x.start), 64'(x.lat));
      chk("sram_ce_count", i, 64'(ce_cnt[i]), 64'(x.ce));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ack1, rdat1, err1, ce1, we1, addr1, wdat1);
      mon(1, ack4, rdat4, err4, ce4, we4, addr4, wdat4);
    end
  end

  task automatic wait_ack(input int i);
    bit seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack_w[i]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout dut%0d: got no ack within 20 cycles, expected one", i);
    end
    @(posedge clk);
    #1 req[i] = 1'b0;
  endtask

  task automatic raise(input logic wr, input logic rd, input logic [31:0] addr, input logic [63:0] wd);
    mem_addr = addr; mem_wr_en = wr; mem_rd_en = rd; mem_wr_data = wd;
    ce_cnt[0] = 0;
    ce_cnt[1] = 0;
    req = 2'b11;
  endtask

  // Entered at posedge+#1; lat1 is the latency for RD_LATENCY=1.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_d, input logic exp_e, input int lat1);
    exp_t x;
    x.data  = exp_d;
    x.err   = exp_e;
    x.start = cyc;
    x.ce    = (lat1 > 1) ? 1 : 0;
    x.lat   = lat1;
    q0.push_back(x);
    x.lat   = lat1 + ((lat1 == 3) ? 3 : 0);
    q1.push_back(x);
    raise(wr, rd, addr, wd);
    fork
      wait_ack(0);
      wait_ack(1);
    join
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ack"}, 0, {63'd0, ack1}, 64'd0);
    chk({name, "_ack"}, 1, {63'd0, ack4}, 64'd0);
    chk({name, "_rd_data"}, 0, rdat1, 64'd0);
    chk({name, "_rd_data"}, 1, rdat4, 64'd0);
    chk({name, "_err"}, 0, {63'd0, err1}, 64'd0);
    chk({name, "_err"}, 1, {63'd0, err4}, 64'd0);
    chk({name, "_ce"}, 0, {63'd0, ce1}, 64'd0);
    chk({name, "_ce"}, 1, {63'd0, ce4}, 64'd0);
    chk({name, "_we"}, 0, {63'd0, we1}, 64'd0);
    chk({name, "_we"}, 1, {63'd0, we4}, 64'd0);
    chk({name, "_addr"}, 0, {54'd0, addr1}, 64'd0);
    chk({name, "_addr"}, 1, {54'd0, addr4}, 64'd0);
    chk({name, "_wdata"}, 0, wdat1, 64'd0);
    chk({name, "_wdata"}, 1, wdat4, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          wr    rd    addr          wdata                  exp_data                              err   lat
    tbl[0]  = '{1'b1, 1'b0, 32'h5,        64'hDEAD_BEEF_0123_4567, 64'h0,                              1'b0, 2};
    tbl[1]  = '{1'b0, 1'b1, 32'h5,        64'h0,                   64'hDEAD_BEEF_0123_4567,            1'b0, 3};
    tbl[2]  = '{1'b1, 1'b0, 32'h3FF,      64'hA5A5_A5A5_A5A5_A5A5, 64'h0,                              1'b0, 2};
    tbl[3]  = '{1'b0, 1'b1, 32'h3FF,      64'h0,                   64'hA5A5_A5A5_A5A5_A5A5,            1'b0, 3};
    tbl[4]  = '{1'b1, 1'b1, 32'h7,        64'hFFFF_0000_FFFF_0000, 64'h0,                              CHK,  1};
    tbl[5]  = '{1'b0, 1'b0, 32'h7,        64'h1234_5678_9ABC_DEF0, 64'h0,                              CHK,  1};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,        64'h1111_2222_3333_4444, 64'h0,                              1'b0, 2};
    tbl[7]  = '{1'b1, 1'b0, 32'h400,      64'h5555_6666_7777_8888, 64'h0,                              CHK,  CHK ? 1 : 2};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,        64'h0,                   CHK ? 64'h1111_2222_3333_4444
                                                                       : 64'h5555_6666_7777_8888,      1'b0, 3};
    tbl[9]  = '{1'b0, 1'b1, 32'h400,      64'h0,                   CHK ? 64'h0 : 64'h5555_6666_7777_8888, CHK, CHK ? 1 : 3};
    tbl[10] = '{1'b0, 1'b1, 32'h5,        64'h0,                   64'hDEAD_BEEF_0123_4567,            1'b0, 3};
    tbl[11] = '{1'b1, 1'b0, 32'hFFFF_0012, 64'h0BAD_F00D_CAFE_0001, 64'h0,                             CHK,  CHK ? 1 : 2};
    tbl[12] = '{1'b0, 1'b1, 32'h12,       64'h0,                   CHK ? 64'h0 : 64'h0BAD_F00D_CAFE_0001, 1'b0, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 13; v++)
      access(tbl[v].wr, tbl[v].rd, tbl[v].addr, tbl[v].wdata,
             tbl[v].exp_data, tbl[v].exp_err, tbl[v].exp_lat);

    // soft_rst while both responders sit in S_WAIT of a read
    raise(1'b0, 1'b1, 32'h5, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 begin
      soft_rst = 1'b1;
      req = 2'b00;
    end
    @(posedge clk);
    #1 soft_rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("soft_rst_no_ack", 0, {63'd0, ack1}, 64'd0);
      chk("soft_rst_no_ack", 1, {63'd0, ack4}, 64'd0);
    end
    @(posedge clk);
    #1 access(1'b1, 1'b0, 32'h7, 64'h7777_0000_7777_0000, 64'h0, 1'b0, 2);
    access(1'b0, 1'b1, 32'h7, 64'h0, 64'h7777_0000_7777_0000, 1'b0, 3);

    // asynchronous reset in the SRAM access cycle of a read
    raise(1'b0, 1'b1, 32'h3FF, 64'h0);
    @(posedge clk);
    #3;
    chk("pre_rst_ce", 0, {63'd0, ce1}, 64'd1);
    chk("pre_rst_addr", 1, {54'd0, addr4}, 64'h3FF);
    rst = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 access(1'b1, 1'b0, 32'h20, 64'hCAFE_BABE_0000_1111, 64'h0, 1'b0, 2);
    access(1'b0, 1'b1, 32'h20, 64'h0, 64'hCAFE_BABE_0000_1111, 1'b0, 3);
    access(1'b0, 1'b1, 32'h3FF, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 3);

    repeat (4) @(posedge clk);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
